imm_gen_pipe: RTL
=================

IMM_GEN_PIPE -- requirements
Module: imm_gen_pipe

Interface
REQ-001 SHALL have parameter XLEN, default 32, immediate output width; legal values 32, 64.
REQ-002 SHALL have parameter DEPTH, default 2, output buffer entries; legal range 1..4.
REQ-003 SHALL have port Clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port ResetN  input  1  synchronous, active-low reset.
REQ-005 SHALL have port InValid  input  1  instruction present on Instruction/ImGenControl.
REQ-006 SHALL have port InReady  output  1  block can accept; registered, no combinational path from OutReady.
REQ-007 SHALL have port Instruction  input  32  raw RV32I/RV64I instruction word.
REQ-008 SHALL have port ImGenControl  input  3  immediate format select.
REQ-009 SHALL have port Flush  input  1  discard all buffered and incoming entries.
REQ-010 SHALL have port OutValid  output  1  head entry valid.
REQ-011 SHALL have port OutReady  input  1  consumer takes head entry.
REQ-012 SHALL have port Immediate  output  XLEN  sign/zero-extended immediate of head entry.
REQ-013 SHALL have port ImmFormat  output  3  format code of head entry.
REQ-014 SHALL have port IllegalFmt  output  1  head entry used reserved format.

Function
REQ-015 SHALL accept an entry when InValid && InReady; SHALL pop head when OutValid && OutReady.
REQ-016 SHALL present an accepted entry on the outputs no earlier than the cycle after acceptance (latency 1 when empty).
REQ-017 SHALL assert InReady iff occupancy < DEPTH; push and pop in one cycle leave occupancy unchanged.
REQ-018 SHALL deliver entries strictly in acceptance order; pointers wrap modulo DEPTH.
REQ-019 SHALL decode 000 I: sext Instr[31:20]; 001 S: sext {Instr[31:25],Instr[11:7]}; 010 B: sext {Instr[31],Instr[7],Instr[30:25],Instr[11:8],1'b0}.
REQ-020 SHALL decode 011 J: sext {Instr[31],Instr[19:12],Instr[20],Instr[30:21],1'b0}; 100 U: sext {Instr[31:12],12'b0}.
REQ-021 SHALL decode 101 CSR zimm: zext Instr[19:15]; 110 shamt: zext Instr[24:20] (XLEN=32) or Instr[25:20] (XLEN=64).
REQ-022 SHALL for 111 output Immediate 0 and IllegalFmt 1; IllegalFmt 0 for all other codes.
REQ-023 SHALL compute the immediate before buffering; buffer stores XLEN+4 bits per entry.
REQ-024 SHALL, on Flush, set occupancy 0 and pointers 0 next cycle, ignoring a same-cycle push and pop.
REQ-025 SHALL hold Immediate, ImmFormat, IllegalFmt at 0 while OutValid is 0.
REQ-026 SHALL keep head outputs stable while OutValid && !OutReady.

Reset
REQ-027 SHALL, with ResetN low at a rising edge, clear occupancy and pointers, giving OutValid 0, InReady 1, Immediate 0, ImmFormat 0, IllegalFmt 0.
REQ-028 SHALL discard in-flight entries on reset mid-operation; Reset takes priority over Flush, push and pop.

Configuration
REQ-029 SHALL support macro IMM_GEN_AUTODECODE_EN; when defined, format derives from Instr[6:0] and ImGenControl is ignored.
REQ-030 SHALL autodecode: 0000011/0010011/1100111 I (0010011 with funct3 001/101 shamt); 0100011 S; 1100011 B; 1101111 J; 0110111/0010111 U; 1110011 funct3[2]=1 zimm, else I; other opcodes 111.
REQ-031 SHALL, when undefined, use ImGenControl only and contain no opcode-decode logic.

Structure
REQ-032 SHALL place imm_fmt_e enum (7 codes + illegal) and opcode constants in package imm_gen_pkg.
REQ-033 SHALL implement the buffer as sub-module imm_gen_fifo (parametrised width, DEPTH), with imm_gen_pipe holding extraction logic.

Verification
REQ-034 SHALL check 0xFFF00093, fmt 000 -> one cycle later Immediate 0xFFFFFFFF, OutValid 1; 0xFE112E23, fmt 001 -> 0xFFFFFFFC.
REQ-035 SHALL check 0xFE000CE3, fmt 010 -> 0xFFFFFFF8; 0x0010006F, fmt 011 -> 0x00000800; 0x123450B7, fmt 100 -> 0x12345000; XLEN=64, 0x80000037, fmt 100 -> 0xFFFFFFFF80000000.
REQ-036 SHALL check DEPTH=2, OutReady 0, three pushes -> InReady 0 after second, third held; OutReady 1 -> three entries out in order.
REQ-037 SHALL check Flush with full buffer and InValid 1 -> next cycle OutValid 0, InReady 1, nothing delivered.
REQ-038 SHALL check fmt 111 -> Immediate 0, IllegalFmt 1; ResetN low with two entries buffered -> all outputs at reset values next cycle.
REQ-039 SHALL, with IMM_GEN_AUTODECODE_EN, check 0x00509093 with ImGenControl 011 -> ImmFormat 110, Immediate 0x00000005.

Source files
------------

// File: rtl/imm_gen_pkg.sv
// Immediate format codes and RV32I/RV64I major opcodes shared by the immediate pipe.
package imm_gen_pkg;

  typedef enum logic [2:0] {
    FMT_I       = 3'b000,
    FMT_S       = 3'b001,
    FMT_B       = 3'b010,
    FMT_J       = 3'b011,
    FMT_U       = 3'b100,
    FMT_ZIMM    = 3'b101,
    FMT_SHAMT   = 3'b110,
    FMT_ILLEGAL = 3'b111
  } imm_fmt_e;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;

endpackage

// File: rtl/imm_gen_fifo.sv
// Circular output buffer, DEPTH entries of WIDTH bits; a pushed entry is visible one cycle later.
// ready is a flop (no path from pop); flush/reset empty it; dout reads zero while empty.
module imm_gen_fifo #(
  parameter int WIDTH = 36,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  output logic             ready,
  input  logic             pop,
  output logic             valid,
  output logic [WIDTH-1:0] dout
);

  localparam int            PW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PW-1:0] LAST = PW'(DEPTH - 1);
  localparam logic [2:0]    CAP  = 3'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [2:0]       count;
  logic [2:0]       count_nxt;
  logic             do_push;
  logic             do_pop;

  assign valid   = (count != 3'd0);
  assign do_push = push && ready;
  assign do_pop  = pop && valid;
  assign dout    = valid ? mem[rd_ptr] : '0;

  always_comb begin
    count_nxt = count;
    if (do_push && !do_pop) count_nxt = count + 3'd1;
    else if (!do_push && do_pop) count_nxt = count - 3'd1;
  end

  // Reset and flush both return to empty; a same-cycle push or pop is dropped.
  always_ff @(posedge clk) begin
    if (!rst_n || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= 3'd0;
      ready  <= 1'b1;
    end else begin
      count <= count_nxt;
      ready <= (count_nxt < CAP);
      if (do_push) wr_ptr <= (wr_ptr == LAST) ? '0 : wr_ptr + PW'(1);
      if (do_pop)  rd_ptr <= (rd_ptr == LAST) ? '0 : rd_ptr + PW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/imm_gen_pipe.sv
// Extracts the RV immediate for the selected format and buffers {illegal, fmt, imm}; latency 1, InReady registered.
// IMM_GEN_AUTODECODE_EN derives the format from the opcode instead of ImGenControl.
module imm_gen_pipe
  import imm_gen_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int DEPTH = 2
) (
  input  logic            Clk,
  input  logic            ResetN,
  input  logic            InValid,
  output logic            InReady,
  input  logic [31:0]     Instruction,
  input  logic [2:0]      ImGenControl,
  input  logic            Flush,
  output logic            OutValid,
  input  logic            OutReady,
  output logic [XLEN-1:0] Immediate,
  output logic [2:0]      ImmFormat,
  output logic            IllegalFmt
);

  localparam int W = XLEN + 4;

  imm_fmt_e        fmt;
  logic [XLEN-1:0] imm;
  logic            illegal;
  logic [W-1:0]    entry;
  logic [W-1:0]    head;

`ifdef IMM_GEN_AUTODECODE_EN
  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [2:0] unused_ctl;

  assign opcode     = Instruction[6:0];
  assign funct3     = Instruction[14:12];
  assign unused_ctl = ImGenControl;

  always_comb begin
    fmt = FMT_ILLEGAL;
    case (opcode)
      OP_LOAD, OP_JALR: fmt = FMT_I;
      OP_IMM:           fmt = (funct3 == 3'b001 || funct3 == 3'b101) ? FMT_SHAMT : FMT_I;
      OP_STORE:         fmt = FMT_S;
      OP_BRANCH:        fmt = FMT_B;
      OP_JAL:           fmt = FMT_J;
      OP_LUI, OP_AUIPC: fmt = FMT_U;
      OP_SYSTEM:        fmt = funct3[2] ? FMT_ZIMM : FMT_I;
      default:          fmt = FMT_ILLEGAL;
    endcase
  end
`else
  logic unused_opcode;

  assign fmt           = imm_fmt_e'(ImGenControl);
  assign unused_opcode = ^Instruction[6:0];
`endif

  // Signed size casts do the sign extension for every XLEN.
  always_comb begin
    imm     = '0;
    illegal = 1'b0;
    case (fmt)
      FMT_I:     imm = XLEN'($signed(Instruction[31:20]));
      FMT_S:     imm = XLEN'($signed({Instruction[31:25], Instruction[11:7]}));
      FMT_B:     imm = XLEN'($signed({Instruction[31], Instruction[7], Instruction[30:25],
                                      Instruction[11:8], 1'b0}));
      FMT_J:     imm = XLEN'($signed({Instruction[31], Instruction[19:12], Instruction[20],
                                      Instruction[30:21], 1'b0}));
      FMT_U:     imm = XLEN'($signed({Instruction[31:12], 12'b0}));
      FMT_ZIMM:  imm = XLEN'(Instruction[19:15]);
      FMT_SHAMT: imm = (XLEN == 64) ? XLEN'(Instruction[25:20]) : XLEN'(Instruction[24:20]);
      default: begin
        imm     = '0;
        illegal = 1'b1;
      end
    endcase
  end

  assign entry = {illegal, fmt, imm};

  imm_gen_fifo #(
    .WIDTH(W),
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk  (Clk),
    .rst_n(ResetN),
    .flush(Flush),
    .push (InValid),
    .din  (entry),
    .ready(InReady),
    .pop  (OutReady),
    .valid(OutValid),
    .dout (head)
  );

  assign Immediate  = head[XLEN-1:0];
  assign ImmFormat  = head[XLEN+2:XLEN];
  assign IllegalFmt = head[XLEN+3];

endmodule
